// File: rtl/image_packer_if.sv
// rtl/image_packer_if.sv - pixel byte stream in, packed weight-RAM write port out
interface image_packer_if;
  logic [7:0]        i_PX_DIN;
  logic              i_PX_VALID;
  logic              o_PX_READY;
  logic [9:0]        o_RAM_ADDR;
  logic [0:261][7:0] o_RAM_DIN;
  logic              o_RAM_WE;

  modport master (
    output i_PX_DIN, i_PX_VALID,
    input  o_PX_READY, o_RAM_ADDR, o_RAM_DIN, o_RAM_WE
  );

  modport slave (
    input  i_PX_DIN, i_PX_VALID,
    output o_PX_READY, o_RAM_ADDR, o_RAM_DIN, o_RAM_WE
  );
endinterface

// File: rtl/image_packer.sv
// rtl/image_packer.sv - packs a quantized image byte stream into three 262-lane RAM words
module image_packer #(
  parameter logic [9:0] BASE_ADDR = 10'd960,
  parameter int         NBYTES    = 784
) (
  input  logic          i_CLK,
  input  logic          i_RST_n,
  input  logic          i_START,
  image_packer_if.slave px_ram,
  output logic          o_BUSY,
  output logic          o_DONE
);
  localparam int         LANES     = 262;
  localparam logic [8:0] LAST_FULL = 9'(LANES - 1);
  localparam logic [8:0] LAST_TAIL = 9'(NBYTES - 2 * LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;
  typedef logic [0:LANES-1][7:0] word_t;

  state_t     state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [1:0] chunk_q, chunk_d;
  word_t      buf_q, buf_d;
  word_t      din_d;
  logic [9:0] addr_d;
  logic       ready_d, we_d, busy_d, done_d;
  logic       accept, chunk_end;

  // READY is registered from the next state, so it is high exactly in FILL cycles.
  assign accept    = (state_q == S_FILL) && px_ram.o_PX_READY && px_ram.i_PX_VALID;
  assign chunk_end = accept && (cnt_q == ((chunk_q == 2'd2) ? LAST_TAIL : LAST_FULL));

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_START) state_d = S_FILL;
      S_FILL:  if (chunk_end) state_d = S_WRITE;
      S_WRITE: state_d = (chunk_q == 2'd2) ? S_DONE : S_FILL;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    chunk_d = chunk_q;
    buf_d   = buf_q;
    addr_d  = px_ram.o_RAM_ADDR;
    din_d   = px_ram.o_RAM_DIN;
    we_d    = 1'b0;
    ready_d = (state_d == S_FILL);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (i_START) begin
          cnt_d   = '0;
          chunk_d = '0;
          buf_d   = '0;
        end
      end
      S_FILL: begin
        if (accept) begin
          buf_d[cnt_q] = px_ram.i_PX_DIN;
          cnt_d        = cnt_q + 9'd1;
        end
        // The write word captures the final byte in the same edge it is accepted.
        if (chunk_end) begin
          we_d   = 1'b1;
          addr_d = BASE_ADDR + {8'd0, chunk_q};
          din_d  = buf_d;
        end
      end
      S_WRITE: begin
        buf_d = '0;
        cnt_d = '0;
        if (chunk_q != 2'd2) chunk_d = chunk_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      cnt_q             <= '0;
      chunk_q           <= '0;
      buf_q             <= '0;
      px_ram.o_PX_READY <= 1'b0;
      px_ram.o_RAM_WE   <= 1'b0;
      px_ram.o_RAM_ADDR <= '0;
      px_ram.o_RAM_DIN  <= '0;
      o_BUSY            <= 1'b0;
      o_DONE            <= 1'b0;
    end else begin
      cnt_q             <= cnt_d;
      chunk_q           <= chunk_d;
      buf_q             <= buf_d;
      px_ram.o_PX_READY <= ready_d;
      px_ram.o_RAM_WE   <= we_d;
      px_ram.o_RAM_ADDR <= addr_d;
      px_ram.o_RAM_DIN  <= din_d;
      o_BUSY            <= busy_d;
      o_DONE            <= done_d;
    end
  end
endmodule

// File: doc/image_packer.md
IMAGE_PACKER -- requirements
Module: image_packer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 10'd960, RAM word address of quantized image chunk 0.
REQ-002 SHALL have parameter NBYTES, default 784, image bytes per frame (fixed chunking 262/262/260).
REQ-003 SHALL have port i_CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_RST_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_START  input  1  one-cycle pulse arming a frame load.
REQ-006 SHALL have port i_PX_DIN  input  8  quantized pixel byte.
REQ-007 SHALL have port i_PX_VALID  input  1  pixel byte valid.
REQ-008 SHALL have port o_PX_READY  output  1  packer accepts byte this cycle.
REQ-009 SHALL have port o_RAM_ADDR  output  10  write address to weight RAM port.
REQ-010 SHALL have port o_RAM_DIN  output  8 x [0:261]  packed 262-lane write word, lane p = byte p of chunk.
REQ-011 SHALL have port o_RAM_WE  output  1  one-cycle write strobe.
REQ-012 SHALL have port o_BUSY  output  1  high from accepted START until DONE cycle inclusive.
REQ-013 SHALL have port o_DONE  output  1  one-cycle pulse, frame fully written.

Function
REQ-014 SHALL implement FSM states IDLE, FILL, WRITE, DONE; all outputs registered.
REQ-015 IDLE: i_START=1 -> FILL, chunk index=0, lane counter=0, lane buffer all zero; otherwise stay.
REQ-016 FILL: o_PX_READY=1; byte accepted iff i_PX_VALID&&o_PX_READY; accepted byte stored in lane[counter], counter+1.
REQ-017 Chunk ends on acceptance of lane 261 (chunks 0,1) or lane 259 (chunk 2) -> WRITE next cycle; o_PX_READY=0 in that WRITE cycle.
REQ-018 WRITE: lasts exactly one cycle; o_RAM_WE=1, o_RAM_ADDR=BASE_ADDR+chunk, o_RAM_DIN=lane buffer including final byte.
REQ-019 Chunk 2 lanes 260,261 SHALL be written as 8'h00.
REQ-020 After WRITE: lane buffer cleared, counter=0; chunk<2 -> chunk+1, FILL; chunk=2 -> DONE.
REQ-021 DONE: o_DONE=1 for one cycle, o_BUSY=1, then IDLE with o_BUSY=0.
REQ-022 Latency: last byte of chunk accepted at edge N -> o_RAM_WE high during cycle after N; final write -> o_DONE next cycle.
REQ-023 Minimum frame time with VALID held high: 1 (START) + 784 + 3 WRITE + 1 DONE = 789 cycles.
REQ-024 i_PX_VALID low in FILL SHALL stall without state change; bytes presented outside FILL SHALL be ignored.
REQ-025 i_START while not IDLE SHALL be ignored (no restart, no counter change).
REQ-026 o_RAM_WE SHALL be 0 in all states except WRITE; o_RAM_ADDR/o_RAM_DIN hold last value otherwise.
REQ-027 Exactly three writes per frame, addresses BASE_ADDR, +1, +2 in order; no other address ever written.

Reset
REQ-028 i_RST_n low SHALL immediately force IDLE, chunk=0, counter=0, buffer zero.
REQ-029 Reset values: o_PX_READY=0, o_RAM_WE=0, o_RAM_ADDR=10'd0, o_RAM_DIN all 8'h00, o_BUSY=0, o_DONE=0.
REQ-030 Reset mid-frame SHALL abort without any further write; partially packed chunk discarded; next START begins at chunk 0.

Verification
REQ-031 Bench: START, 784 bytes value=index mod 256, VALID always high -> WE at 960/961/962; word0 lane p=p mod 256, word2 lane 259=8'h0F, lanes 260-261=0; DONE at cycle 789.
REQ-032 Bench: random VALID gaps (50% duty) -> identical three words as REQ-031, READY low only in non-FILL states.
REQ-033 Bench: START pulsed during FILL chunk 1 -> ignored, frame completes with exactly 3 writes, one DONE.
REQ-034 Bench: reset asserted after 400 bytes, then START + 784 bytes 8'hA5 -> no write during reset, then 3 writes all lanes 8'hA5 (chunk 2 lanes 260-261=0).
REQ-035 Bench: BASE_ADDR=10'd100 -> writes at 100,101,102 only.
REQ-036 Bench: two back-to-back frames (START in cycle after DONE) -> second frame's writes not contaminated by first (buffer cleared).
